// File: rtl/control_edicion_campos_if.sv
// Button levels in, field-select code and edit strobes out.
interface control_edicion_campos_if;
  logic       btn_prog;
  logic       btn_izq;
  logic       btn_der;
  logic       btn_arriba;
  logic       btn_abajo;
  logic [3:0] contadoresH;
  logic       Arriba;
  logic       Abajo;
  logic       modo_edicion;
  logic       escribir;

  // Button panel side
  modport master (
    output btn_prog, btn_izq, btn_der, btn_arriba, btn_abajo,
    input  contadoresH, Arriba, Abajo, modo_edicion, escribir
  );

  // Edit controller side
  modport slave (
    input  btn_prog, btn_izq, btn_der, btn_arriba, btn_abajo,
    output contadoresH, Arriba, Abajo, modo_edicion, escribir
  );
endinterface

// File: rtl/control_edicion_campos.sv
// Edit-mode controller for the clock/timer counter bank: field navigation,
// one-cycle up/down strobes with hold-to-repeat, inactivity cancel, commit strobe.
module control_edicion_campos #(
  parameter logic [3:0]  FIRST_FIELD    = 4'd1,
  parameter logic [3:0]  LAST_FIELD     = 4'd10,
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REP_CYCLES     = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  control_edicion_campos_if.slave bus
);

  localparam int unsigned REP_MAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT
  } state_t;

  state_t           r_state, w_state_next;
  logic             r_prog_q, r_izq_q, r_der_q, r_arr_q, r_abj_q;
  logic [3:0]       r_field, w_field_next;
  logic             r_arriba, w_arriba_next;
  logic             r_abajo, w_abajo_next;
  logic             r_modo, w_modo_next;
  logic             r_escribir, w_escribir_next;
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_next, w_rep_inc;
  logic             r_repeating, w_repeating_next;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_next;

  logic w_rise_prog, w_rise_izq, w_rise_der, w_rise_arr, w_rise_abj;
  logic w_up_alone, w_dn_alone, w_alone, w_rise_alone, w_prev_alone_same;
  logic w_activity, w_field_chg, w_pulse;

  assign w_rise_prog = bus.btn_prog   & ~r_prog_q;
  assign w_rise_izq  = bus.btn_izq    & ~r_izq_q;
  assign w_rise_der  = bus.btn_der    & ~r_der_q;
  assign w_rise_arr  = bus.btn_arriba & ~r_arr_q;
  assign w_rise_abj  = bus.btn_abajo  & ~r_abj_q;

  assign w_up_alone   = bus.btn_arriba & ~bus.btn_abajo;
  assign w_dn_alone   = bus.btn_abajo  & ~bus.btn_arriba;
  assign w_alone      = w_up_alone | w_dn_alone;
  assign w_rise_alone = (w_up_alone & w_rise_arr) | (w_dn_alone & w_rise_abj);
  // Same single button was held alone last cycle: the hold run continues.
  // Otherwise (previous cycle had both held) the run restarts without a pulse.
  assign w_prev_alone_same = (w_up_alone & r_arr_q & ~r_abj_q) |
                             (w_dn_alone & r_abj_q & ~r_arr_q);

  assign w_activity  = w_rise_izq | w_rise_der | w_rise_arr | w_rise_abj |
                       bus.btn_arriba | bus.btn_abajo;
  assign w_field_chg = w_rise_izq ^ w_rise_der;

  assign w_rep_inc = (r_rep_cnt == REP_W'(REP_MAX)) ? r_rep_cnt : r_rep_cnt + REP_W'(1);

  assign bus.contadoresH  = r_field;
  assign bus.Arriba       = r_arriba;
  assign bus.Abajo        = r_abajo;
  assign bus.modo_edicion = r_modo;
  assign bus.escribir     = r_escribir;

  // State, registered outputs, counters and previous button samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prog_q    <= 1'b0;
      r_izq_q     <= 1'b0;
      r_der_q     <= 1'b0;
      r_arr_q     <= 1'b0;
      r_abj_q     <= 1'b0;
      r_field     <= '0;
      r_arriba    <= 1'b0;
      r_abajo     <= 1'b0;
      r_modo      <= 1'b0;
      r_escribir  <= 1'b0;
      r_rep_cnt   <= '0;
      r_repeating <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_prog_q    <= bus.btn_prog;
      r_izq_q     <= bus.btn_izq;
      r_der_q     <= bus.btn_der;
      r_arr_q     <= bus.btn_arriba;
      r_abj_q     <= bus.btn_abajo;
      r_field     <= w_field_next;
      r_arriba    <= w_arriba_next;
      r_abajo     <= w_abajo_next;
      r_modo      <= w_modo_next;
      r_escribir  <= w_escribir_next;
      r_rep_cnt   <= w_rep_cnt_next;
      r_repeating <= w_repeating_next;
      r_to_cnt    <= w_to_cnt_next;
    end
  end

  // Next state, next outputs, repeat and timeout counters
  always_comb begin
    w_state_next     = r_state;
    w_field_next     = r_field;
    w_arriba_next    = 1'b0;
    w_abajo_next     = 1'b0;
    w_modo_next      = 1'b0;
    w_escribir_next  = 1'b0;
    w_rep_cnt_next   = '0;
    w_repeating_next = 1'b0;
    w_to_cnt_next    = '0;
    w_pulse          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_field_next = '0;
        if (w_rise_prog) begin
          w_state_next = ST_EDIT;
          w_field_next = FIRST_FIELD;
          w_modo_next  = 1'b1;
        end
      end

      ST_COMMIT: begin
        w_state_next = ST_IDLE;
        w_field_next = '0;
      end

      ST_EDIT: begin
        if (w_rise_prog) begin
          w_state_next    = ST_COMMIT;
          w_field_next    = '0;
          w_escribir_next = 1'b1;
        end else if (!w_activity && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = ST_IDLE;
          w_field_next = '0;
        end else begin
          w_modo_next = 1'b1;
          if (!w_activity)
            w_to_cnt_next = (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) ? r_to_cnt : r_to_cnt + TO_W'(1);

          if (w_rise_der && !w_rise_izq)
            w_field_next = (r_field == LAST_FIELD) ? FIRST_FIELD : r_field + 4'd1;
          else if (w_rise_izq && !w_rise_der)
            w_field_next = (r_field == FIRST_FIELD) ? LAST_FIELD : r_field - 4'd1;

          // A field change suppresses the strobe and restarts the hold wait.
          if (w_alone && !w_field_chg) begin
            if (w_rise_alone) begin
              w_pulse = 1'b1;
            end else if (w_prev_alone_same) begin
              if ((!r_repeating && w_rep_inc == REP_W'(HOLD_CYCLES)) ||
                  ( r_repeating && w_rep_inc == REP_W'(REP_CYCLES))) begin
                w_pulse          = 1'b1;
                w_repeating_next = 1'b1;
              end else begin
                w_rep_cnt_next   = w_rep_inc;
                w_repeating_next = r_repeating;
              end
            end
          end
          w_arriba_next = w_pulse & w_up_alone;
          w_abajo_next  = w_pulse & w_dn_alone;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_field_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_edicion_campos.sv
// Directed and randomized bench for control_edicion_campos with a cycle-indexed reference model.
module tb_control_edicion_campos;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int TO   = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_edicion_campos_if bus();

  control_edicion_campos #(
    .FIRST_FIELD(4'd1),
    .LAST_FIELD(4'd10),
    .HOLD_CYCLES(HOLD),
    .REP_CYCLES(REP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode, field, and timing kept as absolute cycle indices
  int     m_state;            // 0 idle, 1 edit, 2 commit
  int     m_field;
  logic   m_up, m_dn, m_esc;
  longint t, last_act, anchor;
  logic   p_prog, p_izq, p_der, p_arr, p_abj;

  // Counter bank fed by the strobes (code 1 = hours, 10 = timer hours)
  int bank [1:10];
  int modv [1:10];
  int n_up, n_dn, n_esc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_field = 0; m_up = 0; m_dn = 0; m_esc = 0;
    p_prog = 0; p_izq = 0; p_der = 0; p_arr = 0; p_abj = 0;
    anchor = t; last_act = t;
  endtask

  task automatic model_step();
    logic rp, ri, rd, ru, rb, arr, abj, ua, da, act, pulse;
    longint d;
    arr = bus.btn_arriba; abj = bus.btn_abajo;
    rp = bus.btn_prog & ~p_prog;
    ri = bus.btn_izq  & ~p_izq;
    rd = bus.btn_der  & ~p_der;
    ru = arr & ~p_arr;
    rb = abj & ~p_abj;
    m_up = 0; m_dn = 0; m_esc = 0; pulse = 0;
    case (m_state)
      0: begin
        anchor = t;
        if (rp) begin m_state = 1; m_field = 1; last_act = t; end
      end
      2: begin anchor = t; m_state = 0; m_field = 0; end
      default: begin
        if (rp) begin
          m_state = 2; m_field = 0; m_esc = 1; anchor = t;
        end else begin
          act = ri | rd | ru | rb | arr | abj;
          if (!act && (t - last_act) == TO) begin
            m_state = 0; m_field = 0; anchor = t;
          end else begin
            if (act) last_act = t;
            if (rd && !ri)      m_field = (m_field == 10) ? 1 : m_field + 1;
            else if (ri && !rd) m_field = (m_field == 1) ? 10 : m_field - 1;
            ua = arr & ~abj;
            da = abj & ~arr;
            if (ua | da) begin
              if (ri ^ rd) anchor = t;
              else if ((ua & ru) | (da & rb)) begin anchor = t; pulse = 1; end
              else if (p_arr & p_abj) anchor = t;
              else begin
                d = t - anchor;
                pulse = (d == HOLD) || (d > HOLD && ((d - HOLD) % REP) == 0);
              end
            end
            m_up = pulse & ua;
            m_dn = pulse & da;
          end
        end
      end
    endcase
    p_prog = bus.btn_prog; p_izq = bus.btn_izq; p_der = bus.btn_der;
    p_arr = arr; p_abj = abj;
    t++;
  endtask

  task automatic tick();
    logic [7:0] exp;
    @(posedge clk);
    model_step();
    #1;
    exp = {4'(m_field), m_up, m_dn, (m_state == 1) ? 1'b1 : 1'b0, m_esc};
    check("cycle_outputs",
          {24'd0, bus.contadoresH, bus.Arriba, bus.Abajo, bus.modo_edicion, bus.escribir},
          {24'd0, exp});
    if (bus.Arriba) n_up++;
    if (bus.Abajo)  n_dn++;
    if (bus.escribir) n_esc++;
    if (bus.contadoresH >= 4'd1 && bus.contadoresH <= 4'd10) begin
      if (bus.Arriba) bank[bus.contadoresH] = (bank[bus.contadoresH] + 1) % modv[bus.contadoresH];
      if (bus.Abajo)  bank[bus.contadoresH] = (bank[bus.contadoresH] + modv[bus.contadoresH] - 1) % modv[bus.contadoresH];
    end
  endtask

  task automatic press_prog();
    bus.btn_prog = 1; tick();
    bus.btn_prog = 0; tick();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {24'd0, bus.contadoresH, bus.Arriba, bus.Abajo, bus.modo_edicion, bus.escribir}, 32'd0);
  endtask

  initial begin
    t = 0;
    modv = '{24, 60, 60, 31, 12, 100, 24, 60, 60, 24};
    foreach (bank[i]) bank[i] = 0;
    n_up = 0; n_dn = 0; n_esc = 0;
    bus.btn_prog = 0; bus.btn_izq = 0; bus.btn_der = 0; bus.btn_arriba = 0; bus.btn_abajo = 0;
    reset = 1;
    model_reset();
    #22;
    check_all_zero("reset_state");
    reset = 0;

    // 1: enter edit, then asynchronous reset between clock edges
    press_prog();
    bus.btn_der = 1; tick();
    bus.btn_der = 0; tick();
    check("field_before_async_reset", {28'd0, bus.contadoresH}, 32'd2);
    #2 reset = 1;
    model_reset();
    #1 check_all_zero("async_reset");
    #1 reset = 0;
    press_prog();
    check("enter_field", {28'd0, bus.contadoresH}, 32'd1);
    check("enter_modo", {31'd0, bus.modo_edicion}, 32'd1);

    // 2: wrap-around navigation
    bus.btn_izq = 1; tick();
    check("izq_wrap_1_to_10", {28'd0, bus.contadoresH}, 32'd10);
    bus.btn_izq = 0; tick();
    bus.btn_der = 1; tick();
    check("der_wrap_10_to_1", {28'd0, bus.contadoresH}, 32'd1);
    bus.btn_der = 0; tick();
    bus.btn_izq = 1; tick();
    check("izq_1_to_10", {28'd0, bus.contadoresH}, 32'd10);
    bus.btn_izq = 0; tick();
    bus.btn_izq = 1; bus.btn_der = 1; tick();
    check("both_nav_unchanged", {28'd0, bus.contadoresH}, 32'd10);
    bus.btn_izq = 0; bus.btn_der = 0; tick();

    // 3: hold arriba 30 cycles at field 10
    n_up = 0; n_dn = 0;
    bus.btn_arriba = 1;
    repeat (30) tick();
    bus.btn_arriba = 0; tick();
    check("hold_pulse_count", n_up, 32'd7);
    check("bank10_after_hold", bank[10], 32'd7);

    // 4: both held gives nothing; single abajo wraps hours down
    bus.btn_der = 1; tick();
    bus.btn_der = 0; tick();
    check("field_hours", {28'd0, bus.contadoresH}, 32'd1);
    n_up = 0; n_dn = 0;
    bus.btn_arriba = 1; bus.btn_abajo = 1;
    repeat (20) tick();
    bus.btn_arriba = 0; bus.btn_abajo = 0; tick();
    check("both_held_no_strobes", n_up + n_dn, 32'd0);
    bus.btn_abajo = 1; tick();
    bus.btn_abajo = 0; tick();
    check("hours_down_wrap", bank[1], 32'd23);

    // 5: commit, and commit priority over navigation
    n_esc = 0;
    bus.btn_prog = 1; tick();
    check("commit_escribir", {31'd0, bus.escribir}, 32'd1);
    check("commit_field_zero", {28'd0, bus.contadoresH}, 32'd0);
    bus.btn_prog = 0; tick();
    check("commit_one_cycle", n_esc, 32'd1);
    check("after_commit_idle", {31'd0, bus.modo_edicion}, 32'd0);
    press_prog();
    bus.btn_prog = 1; bus.btn_der = 1; tick();
    check("commit_priority", {31'd0, bus.escribir}, 32'd1);
    bus.btn_prog = 0; bus.btn_der = 0; tick();

    // 6: inactivity timeout cancels without commit
    press_prog();
    n_esc = 0;
    repeat (38) tick();
    check("timeout_not_yet", {31'd0, bus.modo_edicion}, 32'd1);
    tick();
    check("timeout_exit", {31'd0, bus.modo_edicion}, 32'd0);
    check("timeout_no_commit", n_esc, 32'd0);

    // 6b: reset during a repeat run
    press_prog();
    n_up = 0;
    bus.btn_arriba = 1;
    repeat (10) tick();
    check("repeat_before_reset", n_up, 32'd2);
    #2 reset = 1;
    model_reset();
    #1 check_all_zero("reset_mid_repeat");
    #1 reset = 0;
    n_up = 0;
    repeat (12) tick();
    check("no_pulse_after_reset", n_up, 32'd0);
    bus.btn_arriba = 0; tick();

    // Randomized phase against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.btn_prog   = ~bus.btn_prog;
      if ($urandom_range(0, 7)  == 0) bus.btn_izq    = ~bus.btn_izq;
      if ($urandom_range(0, 7)  == 0) bus.btn_der    = ~bus.btn_der;
      if ($urandom_range(0, 11) == 0) bus.btn_arriba = ~bus.btn_arriba;
      if ($urandom_range(0, 11) == 0) bus.btn_abajo  = ~bus.btn_abajo;
      if (i % 500 == 250) begin
        bus.btn_arriba = 0; bus.btn_abajo = 0; bus.btn_izq = 0; bus.btn_der = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
